uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing and buffering controller for the 16x-oversampling UART receiver. It owns the receiver's frame-format configuration and applies new settings only between frames. It arms the receiver with `rx_start`, detects aborted frames (false starts) with a timeout, and tags each received character with its error status. Received characters are pushed into a small FIFO that the host drains through a valid/ready interface. It sits between the receiver and the host/bus register block, all in the `rx_clk` domain.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `CNT_W`, 8: width of error and glitch counters.
- `rx_clk` in 1: 16x-oversampling clock.
- `rst` in 1: reset, asynchronous, active-high; clock is `rx_clk`.
- `enable` in 1: allow reception.
- `cfg_load` in 1: one-cycle pulse; capture `cfg_*` into the pending register.
- `cfg_length` in 4: data bits; values outside 5..8 are stored as 8.
- `cfg_parity_en`, `cfg_parity_type`, `cfg_stop2` in 1 each: frame format.
- `rx_line` in 1: the same synchronized serial line that feeds the receiver.
- `rx_start` out 1: arms the receiver.
- `length` out 4, `parity_en` out 1, `parity_type` out 1, `stop2` out 1: shadow configuration to the receiver.
- `rx_data` in 8, `rx_done` in 1, `rx_error` in 1: receiver outputs.
- `m_data` out 8, `m_err` out 1, `m_valid` out 1, `m_ready` in 1: host stream, FIFO head.
- `busy` out 1: frame in progress.
- `overrun` out 1: sticky; set when a frame is dropped because the FIFO is full.
- `err_count` out CNT_W: saturating count of frames with `m_err` set.
- `glitch_count` out CNT_W: saturating count of timeouts.
- `clr` in 1: clears `overrun`, `err_count` and `glitch_count`.

## Operation
- The FSM has four states: IDLE, APPLY, ARM and FRAME.
- `rx_start` = (state==ARM) && `enable` && !`pend`.
- **IDLE**: if `enable` and `pend`, go to APPLY. If `enable` and no `pend`, go to ARM.
- **APPLY** (1 cycle):
  - Copy the pending config to the shadow config and clear `pend`.
  - Go to ARM if `enable`, else IDLE.
- **ARM**: transitions in priority order.
  - !`enable` → IDLE.
  - `pend` → APPLY.
  - !`rx_line` → FRAME. On this transition, clear `ferr` and load `timer` = 16*(2+length+parity_en+stop2)+15.
- **FRAME**:
  - `rx_error`=1 in any cycle sets `ferr`.
  - `timer` decrements every cycle.
  - On `rx_done`, push {`ferr`, `rx_data`}; `ferr` is tagged as `m_err`.
  - If `timer`==0 and no `rx_done`, increment `glitch_count`; nothing is pushed.
  - After `rx_done` or timeout, the next state is APPLY if `pend`, else ARM if `enable`, else IDLE.
  - `enable` is ignored inside FRAME.
- **Config loading**:
  - `cfg_load` sets `pend` and overwrites the pending config in any state.
  - A second load before apply replaces the first.
  - Shadow config never changes during FRAME.
- **FIFO**:
  - First-word fall-through; `m_valid` = !empty.
  - A pop occurs when `m_valid` && `m_ready`.
  - A push while full and not popping drops the frame and sets `overrun`.
  - Push and pop in the same cycle while full: the push is accepted.
- **Counters**:
  - `err_count` increments on every `rx_done` with the tag set, whether the frame is pushed or dropped.
  - Both counters saturate at all-ones.
  - `clr` beats increment. For `overrun`, set beats `clr`.
- **Arithmetic**: `timer` is 8 bits. The maximum load is 207, for length 8 with parity and two stop bits.

## Timing
- **Reset values**:
  - `rx_start`=0, `busy`=0, `m_valid`=0, `m_data`=0, `m_err`=0, `overrun`=0, counters=0.
  - Shadow config: `length`=8, `parity_en`=0, `parity_type`=0, `stop2`=0. `pend`=0, state=IDLE.
- **Frame start**: ARM→FRAME happens on the same edge on which the receiver leaves idle. `busy` rises the next cycle.
- **Frame end**: `rx_done` (1 cycle) → data appears at `m_data`/`m_valid` the next cycle. `rx_start` is high again one cycle after `rx_done` if nothing is pending.
- **Config apply**: takes 1 cycle (APPLY). `rx_start` is low during APPLY.
- **Timeout**: fires at cycle N+15 after frame start, where N is the nominal cycle of `rx_done`.
- **Mid-operation reset**: `rst` in any state returns everything to the reset values immediately. FIFO contents are discarded.

## Structure
- `uart_pkg` holds:
  - the state enum type;
  - `TIMER_W`=8;
  - default config constants;
  - function `frame_cycles(len, pe, s2)` returning the timer load value.
- `uart_sync_fifo` is a sub-module with parameters DEPTH and WIDTH=9, and ports push/pop/full/empty/dout. It is reusable by the TX side.

## Test plan
- **Defaults**: reset, `enable`=1, send 0xA5 as 8N1 → one entry with `m_data`=0xA5, `m_err`=0, `rx_start` re-asserted 1 cycle after `rx_done`.
- **Parity error**: load length 7, even parity, `stop2`=1; send a frame with a bad parity bit → `m_err`=1, `err_count`=1.
- **Config during frame**: `cfg_load` during FRAME → shadow config unchanged until `rx_done`, then 1-cycle APPLY with `rx_start`=0, then ARM with the new `length`.
- **False start**: 4-cycle low pulse on `rx_line` → no push, `glitch_count`=1 at cycle 175 after start (8N1), then back to ARM.
- **Overrun**: `m_ready`=0, receive 5 frames with DEPTH=4 → 4 entries, `overrun`=1. Then `clr` → `overrun`=0, counters=0.
- **Full-FIFO push/pop**: with the FIFO full, assert `m_ready` in the same cycle as `rx_done` → frame accepted, `overrun` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: controller state
// encoding, shadow-config defaults and the frame timeout computation.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_ARM,
      ST_FRAME
   } rx_state_t;

   localparam int         TIMER_W         = 8;
   localparam int         DATA_W          = 8;
   localparam logic [3:0] DEF_LENGTH      = 4'd8;
   localparam logic       DEF_PARITY_EN   = 1'b0;
   localparam logic       DEF_PARITY_TYPE = 1'b0;
   localparam logic       DEF_STOP2       = 1'b0;

   // 16 ticks per bit over start+data+parity+stop bits, plus 15 ticks of slack.
   function automatic logic [TIMER_W-1:0] frame_cycles(input logic [3:0] len,
                                                       input logic       pe,
                                                       input logic       s2);
      logic [TIMER_W-1:0] bits;
      bits = TIMER_W'(len) + TIMER_W'(pe) + TIMER_W'(s2) + TIMER_W'(2);
      return (bits << 4) + TIMER_W'(15);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: applies frame format between frames, arms the
// receiver, times out false starts and buffers tagged characters for the host.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             rx_clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_load,
   input  logic [3:0]       cfg_length,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_type,
   input  logic             cfg_stop2,
   input  logic             rx_line,
   output logic             rx_start,
   output logic [3:0]       length,
   output logic             parity_en,
   output logic             parity_type,
   output logic             stop2,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   input  logic             rx_error,
   output logic [7:0]       m_data,
   output logic             m_err,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] glitch_count,
   input  logic             clr
);

   rx_state_t          state_q, state_d;
   logic               pend;
   logic [3:0]         pend_length;
   logic               pend_parity_en, pend_parity_type, pend_stop2;
   logic [TIMER_W-1:0] timer_q;
   logic               ferr_q;
   logic               apply, arm_go;
   logic               push, pop, timeout, tag, drop;
   logic               fifo_full, fifo_empty;
   logic [DATA_W:0]    fifo_dout;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign busy     = (state_q == ST_FRAME);
   assign rx_start = (state_q == ST_ARM) && enable && !pend;
   assign push     = (state_q == ST_FRAME) && rx_done;
   assign timeout  = (state_q == ST_FRAME) && !rx_done && (timer_q == '0);
   // An error flagged together with rx_done still belongs to this frame.
   assign tag      = ferr_q | rx_error;
   assign pop      = m_valid && m_ready;
   assign drop     = push && fifo_full && !pop;
   assign m_valid  = !fifo_empty;
   assign {m_err, m_data} = fifo_empty ? '0 : fifo_dout;

   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      arm_go  = 1'b0;
      case (state_q)
         ST_IDLE:  if (enable) state_d = pend ? ST_APPLY : ST_ARM;
         ST_APPLY: begin
            apply   = 1'b1;
            state_d = enable ? ST_ARM : ST_IDLE;
         end
         ST_ARM: begin
            if (!enable)      state_d = ST_IDLE;
            else if (pend)    state_d = ST_APPLY;
            else if (!rx_line) begin
               state_d = ST_FRAME;
               arm_go  = 1'b1;
            end
         end
         ST_FRAME: begin
            if (rx_done || timer_q == '0)
               state_d = pend ? ST_APPLY : (enable ? ST_ARM : ST_IDLE);
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         pend             <= 1'b0;
         pend_length      <= DEF_LENGTH;
         pend_parity_en   <= DEF_PARITY_EN;
         pend_parity_type <= DEF_PARITY_TYPE;
         pend_stop2       <= DEF_STOP2;
         length           <= DEF_LENGTH;
         parity_en        <= DEF_PARITY_EN;
         parity_type      <= DEF_PARITY_TYPE;
         stop2            <= DEF_STOP2;
         timer_q          <= '0;
         ferr_q           <= 1'b0;
         overrun          <= 1'b0;
         err_count        <= '0;
         glitch_count     <= '0;
      end else begin
         state_q <= state_d;
         if (cfg_load) begin
            pend             <= 1'b1;
            pend_length      <= (cfg_length >= 4'd5 && cfg_length <= 4'd8) ? cfg_length : 4'd8;
            pend_parity_en   <= cfg_parity_en;
            pend_parity_type <= cfg_parity_type;
            pend_stop2       <= cfg_stop2;
         end else if (apply) begin
            pend <= 1'b0;
         end
         if (apply) begin
            length      <= pend_length;
            parity_en   <= pend_parity_en;
            parity_type <= pend_parity_type;
            stop2       <= pend_stop2;
         end
         if (arm_go) begin
            timer_q <= frame_cycles(length, parity_en, stop2);
            ferr_q  <= 1'b0;
         end else if (state_q == ST_FRAME) begin
            timer_q <= timer_q - 1'b1;
            if (rx_error) ferr_q <= 1'b1;
         end
         if (drop)     overrun <= 1'b1;
         else if (clr) overrun <= 1'b0;
         if (clr)                 err_count <= '0;
         else if (push && tag)    err_count <= sat_inc(err_count);
         if (clr)                 glitch_count <= '0;
         else if (timeout)        glitch_count <= sat_inc(glitch_count);
      end
   end

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk   (rx_clk),
      .rst   (rst),
      .push  (push),
      .din   ({tag, rx_data}),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; the receiver is emulated by driving
// rx_line / rx_done / rx_data / rx_error directly.
module tb_uart_rx_ctrl;

   logic       rx_clk;
   logic       rst;
   logic       enable;
   logic       cfg_load;
   logic [3:0] cfg_length;
   logic       cfg_parity_en, cfg_parity_type, cfg_stop2;
   logic       rx_line;
   logic       rx_start;
   logic [3:0] length;
   logic       parity_en, parity_type, stop2;
   logic [7:0] rx_data;
   logic       rx_done, rx_error;
   logic [7:0] m_data;
   logic       m_err, m_valid, m_ready;
   logic       busy, overrun;
   logic [7:0] err_count, glitch_count;
   logic       clr;

   int errors = 0;
   int checks = 0;

   uart_rx_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
      .rx_clk(rx_clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
      .cfg_length(cfg_length), .cfg_parity_en(cfg_parity_en),
      .cfg_parity_type(cfg_parity_type), .cfg_stop2(cfg_stop2),
      .rx_line(rx_line), .rx_start(rx_start), .length(length),
      .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
      .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
      .m_data(m_data), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .overrun(overrun), .err_count(err_count),
      .glitch_count(glitch_count), .clr(clr)
   );

   initial rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic start_frame();
      int n = 0;
      while (rx_start !== 1'b1 && n < 50) begin tick(); n++; end
      checks++; if (rx_start !== 1'b1) begin errors++; $display("FAIL arm_wait: rx_start=%b want 1", rx_start); end
      rx_line = 1'b0;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: busy=%b want 1", busy); end
      rx_line = 1'b1;
   endtask

   task automatic finish_frame(input logic [7:0] d, input logic e, input logic rdy);
      repeat (4) tick();
      rx_error = e; tick(); rx_error = 1'b0;
      repeat (4) tick();
      rx_data = d; rx_done = 1'b1; m_ready = rdy;
      tick();
      rx_done = 1'b0; m_ready = 1'b0;
   endtask

   task automatic pop_one();
      m_ready = 1'b1; tick(); m_ready = 1'b0;
   endtask

   task automatic load_cfg(input logic [3:0] l, input logic pe, input logic pt, input logic s2);
      cfg_length = l; cfg_parity_en = pe; cfg_parity_type = pt; cfg_stop2 = s2;
      cfg_load = 1'b1; tick(); cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_length = 4'd0;
      cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; cfg_stop2 = 1'b0;
      rx_line = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0;
      m_ready = 1'b0; clr = 1'b0;
      tick(); tick();
      checks++; if (rx_start !== 1'b0) begin errors++; $display("FAIL rst_rx_start: got %b want 0", rx_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
      checks++; if (m_data !== 8'h00 || m_err !== 1'b0) begin errors++; $display("FAIL rst_m_data: got %h/%b want 00/0", m_data, m_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      checks++; if (err_count !== 8'd0 || glitch_count !== 8'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", err_count, glitch_count); end
      checks++; if (length !== 4'd8) begin errors++; $display("FAIL rst_length: got %0d want 8", length); end
      checks++; if ({parity_en, parity_type, stop2} !== 3'b000) begin errors++; $display("FAIL rst_fmt: got %b want 000", {parity_en, parity_type, stop2}); end
      rst = 1'b0;
      tick();
      checks++; if (rx_start !== 1'b0) begin errors++; $display("FAIL idle_disabled: rx_start=%b want 0", rx_start); end
   endtask

   task automatic test_defaults();
      enable = 1'b1;
      tick();
      checks++; if (rx_start !== 1'b1) begin errors++; $display("FAIL dflt_arm: rx_start=%b want 1", rx_start); end
      start_frame();
      checks++; if (rx_start !== 1'b0) begin errors++; $display("FAIL dflt_frame_start: rx_start=%b want 0", rx_start); end
      finish_frame(8'hA5, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL dflt_data: got %b/%h want 1/a5", m_valid, m_data); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL dflt_err: got %b want 0", m_err); end
      checks++; if (rx_start !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dflt_rearm: rx_start/busy=%b/%b want 1/0", rx_start, busy); end
      pop_one();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL dflt_pop: m_valid=%b want 0", m_valid); end
   endtask

   task automatic test_parity_err();
      load_cfg(4'd7, 1'b1, 1'b0, 1'b1);
      checks++; if (rx_start !== 1'b0 || length !== 4'd8) begin errors++; $display("FAIL par_pend: rx_start/len=%b/%0d want 0/8", rx_start, length); end
      tick();
      checks++; if (rx_start !== 1'b0) begin errors++; $display("FAIL par_apply: rx_start=%b want 0", rx_start); end
      tick();
      checks++; if (length !== 4'd7 || {parity_en, parity_type, stop2} !== 3'b101) begin errors++; $display("FAIL par_shadow: got %0d/%b want 7/101", length, {parity_en, parity_type, stop2}); end
      checks++; if (rx_start !== 1'b1) begin errors++; $display("FAIL par_arm: rx_start=%b want 1", rx_start); end
      start_frame();
      finish_frame(8'h55, 1'b1, 1'b0);
      checks++; if (m_data !== 8'h55 || m_err !== 1'b1) begin errors++; $display("FAIL par_tag: got %h/%b want 55/1", m_data, m_err); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL par_err_count: got %0d want 1", err_count); end
      pop_one();
   endtask

   task automatic test_cfg_during_frame();
      start_frame();
      tick();
      load_cfg(4'd6, 1'b0, 1'b1, 1'b0);
      checks++; if (length !== 4'd7 || parity_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cfgf_hold: len/pe/busy=%0d/%b/%b want 7/1/1", length, parity_en, busy); end
      repeat (3) tick();
      rx_data = 8'h2C; rx_done = 1'b1; tick(); rx_done = 1'b0;
      checks++; if (rx_start !== 1'b0 || length !== 4'd7 || busy !== 1'b0) begin errors++; $display("FAIL cfgf_apply: rx_start/len/busy=%b/%0d/%b want 0/7/0", rx_start, length, busy); end
      tick();
      checks++; if (length !== 4'd6 || {parity_en, parity_type, stop2} !== 3'b010) begin errors++; $display("FAIL cfgf_new: got %0d/%b want 6/010", length, {parity_en, parity_type, stop2}); end
      checks++; if (rx_start !== 1'b1) begin errors++; $display("FAIL cfgf_arm: rx_start=%b want 1", rx_start); end
      checks++; if (m_data !== 8'h2C || m_err !== 1'b0) begin errors++; $display("FAIL cfgf_data: got %h/%b want 2c/0", m_data, m_err); end
      pop_one();
   endtask

   task automatic test_false_start();
      int n;
      load_cfg(4'd12, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      checks++; if (length !== 4'd8 || rx_start !== 1'b1) begin errors++; $display("FAIL fs_len_clamp: len/rx_start=%0d/%b want 8/1", length, rx_start); end
      rx_line = 1'b0;
      tick();
      n = 0;
      repeat (3) begin tick(); n++; end
      rx_line = 1'b1;
      while (glitch_count === 8'd0 && n < 400) begin tick(); n++; end
      // timer reaches 0 in the 176th FRAME cycle for 8N1 (load 175), count updates on its closing edge
      checks++; if (n != 176) begin errors++; $display("FAIL fs_timeout_cycle: got %0d edges want 176", n); end
      checks++; if (glitch_count !== 8'd1) begin errors++; $display("FAIL fs_glitch_count: got %0d want 1", glitch_count); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fs_no_push: m_valid=%b want 0", m_valid); end
      checks++; if (rx_start !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fs_rearm: rx_start/busy=%b/%b want 1/0", rx_start, busy); end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      for (int i = 0; i < 5; i++) begin
         d = 8'h10 + 8'(i);
         start_frame();
         finish_frame(d, (i == 4), 1'b0);
         if (i == 3) begin
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: overrun=%b want 0", overrun); end
         end
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: overrun=%b want 1", overrun); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ovr_err_dropped: got %0d want 2", err_count); end
      for (int i = 0; i < 4; i++) begin
         d = 8'h10 + 8'(i);
         checks++; if (m_valid !== 1'b1 || m_data !== d || m_err !== 1'b0) begin errors++; $display("FAIL ovr_drain%0d: got %b/%h/%b want 1/%h/0", i, m_valid, m_data, m_err, d); end
         pop_one();
      end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: m_valid=%b want 0", m_valid); end
      clr = 1'b1; tick(); clr = 1'b0;
      checks++; if (overrun !== 1'b0 || err_count !== 8'd0 || glitch_count !== 8'd0) begin errors++; $display("FAIL ovr_clr: got %b/%0d/%0d want 0/0/0", overrun, err_count, glitch_count); end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'h20 + 8'(i);
         start_frame();
         finish_frame(d, 1'b0, 1'b0);
      end
      start_frame();
      finish_frame(8'h24, 1'b0, 1'b1);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fpp_overrun: got %b want 0", overrun); end
      for (int i = 1; i < 5; i++) begin
         d = 8'h20 + 8'(i);
         checks++; if (m_valid !== 1'b1 || m_data !== d) begin errors++; $display("FAIL fpp_drain%0d: got %b/%h want 1/%h", i, m_valid, m_data, d); end
         pop_one();
      end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: m_valid=%b want 0", m_valid); end
   endtask

   task automatic test_mid_reset();
      load_cfg(4'd5, 1'b1, 1'b1, 1'b1);
      tick(); tick();
      checks++; if (length !== 4'd5) begin errors++; $display("FAIL mr_pre_len: got %0d want 5", length); end
      start_frame();
      finish_frame(8'h3C, 1'b0, 1'b0);
      start_frame();
      load_cfg(4'd6, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (rx_start !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL mr_ctrl: rx_start/busy/m_valid=%b/%b/%b want 0/0/0", rx_start, busy, m_valid); end
      checks++; if (m_data !== 8'h00 || length !== 4'd8 || {parity_en, parity_type, stop2} !== 3'b000) begin errors++; $display("FAIL mr_values: data/len/fmt=%h/%0d/%b want 00/8/000", m_data, length, {parity_en, parity_type, stop2}); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (rx_start !== 1'b1 || length !== 4'd8) begin errors++; $display("FAIL mr_restart: rx_start/len=%b/%0d want 1/8", rx_start, length); end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_parity_err();
      test_cfg_during_frame();
      test_false_start();
      test_overrun();
      test_full_pushpop();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
